trigger_manager: RTL and testbench

TRIGGER_MANAGER -- requirements
Module: trigger_manager

---
 rtl/trigger_manager.sv | 125 ++++++++++++
 tb/tb_trigger_manager.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/trigger_manager.sv
// Trigger sequencer: IDLE -> PREPARE -> RUN -> PAUSE -> IDLE, Moore outputs registered with the state.
// Optional PREPARE timeout is compiled in with the TRIGGER_MANAGER_TIMEOUT_EN macro.
module trigger_manager #(
    parameter int unsigned PAUSE_CYCLES   = 2,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic trigger,
    input  logic ready,
    input  logic done,
    output logic prepare,
    output logic go,
    output logic pause
`ifdef TRIGGER_MANAGER_TIMEOUT_EN
    ,
    output logic timeout
`endif
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_PREPARE = 2'd1,
        S_RUN     = 2'd2,
        S_PAUSE   = 2'd3
    } state_t;

    generate
        if (PAUSE_CYCLES < 1 || PAUSE_CYCLES > 255 ||
            TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_params
            $error("trigger_manager: parameter out of range");
        end
    endgenerate

    localparam logic [7:0] PAUSE_LOAD = 8'(PAUSE_CYCLES - 1);

    state_t     state;
    logic [7:0] pause_cnt;

`ifdef TRIGGER_MANAGER_TIMEOUT_EN
    localparam logic [15:0] TIMEOUT_LOAD = 16'(TIMEOUT_CYCLES - 1);
    logic [15:0] timeout_cnt;
`endif

    // Outputs are assigned alongside the next state so they always equal the decode of the state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            pause_cnt <= '0;
            prepare   <= 1'b0;
            go        <= 1'b0;
            pause     <= 1'b0;
`ifdef TRIGGER_MANAGER_TIMEOUT_EN
            timeout_cnt <= '0;
            timeout     <= 1'b0;
`endif
        end else begin
            prepare <= 1'b0;
            go      <= 1'b0;
            pause   <= 1'b0;
`ifdef TRIGGER_MANAGER_TIMEOUT_EN
            timeout <= 1'b0;
`endif
            case (state)
                S_IDLE: begin
                    if (trigger) begin
                        state   <= S_PREPARE;
                        prepare <= 1'b1;
`ifdef TRIGGER_MANAGER_TIMEOUT_EN
                        timeout_cnt <= TIMEOUT_LOAD;
`endif
                    end else begin
                        state <= S_IDLE;
                    end
                end
                S_PREPARE: begin
                    // ready wins over both done and an expiring timeout on the same edge
                    if (ready) begin
                        state <= S_RUN;
                        go    <= 1'b1;
                    end else begin
`ifdef TRIGGER_MANAGER_TIMEOUT_EN
                        if (timeout_cnt == '0) begin
                            state     <= S_PAUSE;
                            pause     <= 1'b1;
                            pause_cnt <= PAUSE_LOAD;
                            timeout   <= 1'b1;
                        end else begin
                            state       <= S_PREPARE;
                            prepare     <= 1'b1;
                            timeout_cnt <= timeout_cnt - 16'd1;
                        end
`else
                        state   <= S_PREPARE;
                        prepare <= 1'b1;
`endif
                    end
                end
                S_RUN: begin
                    if (done) begin
                        state     <= S_PAUSE;
                        pause     <= 1'b1;
                        pause_cnt <= PAUSE_LOAD;
                    end else begin
                        state <= S_RUN;
                        go    <= 1'b1;
                    end
                end
                S_PAUSE: begin
                    if (pause_cnt == '0) begin
                        state <= S_IDLE;
                    end else begin
                        state     <= S_PAUSE;
                        pause     <= 1'b1;
                        pause_cnt <= pause_cnt - 8'd1;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_trigger_manager.sv
// Directed plus randomized bench for trigger_manager against a cycle-level behavioural model.
// Compile with +define+TRIGGER_MANAGER_TIMEOUT_EN to also exercise the timeout feature.
module tb_trigger_manager;

    localparam int PAUSE_N   = 2;
    localparam int TIMEOUT_N = 4;

    logic clk;
    logic rst_n;
    logic trigger;
    logic ready;
    logic done;
    logic prepare;
    logic go;
    logic pause;
`ifdef TRIGGER_MANAGER_TIMEOUT_EN
    logic timeout;
`endif

    int checks;
    int errors;

    // Behavioural model: which phase of the sequence we are in and how long we have been there.
    int m_phase;      // 0 idle, 1 prepare, 2 run, 3 pause
    int m_pause_left; // pause cycles still to serve
    int m_prep_age;   // cycles already spent in prepare
    bit m_to;         // timeout pulse expected this cycle

    trigger_manager #(
        .PAUSE_CYCLES  (PAUSE_N),
        .TIMEOUT_CYCLES(TIMEOUT_N)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .trigger(trigger),
        .ready  (ready),
        .done   (done),
        .prepare(prepare),
        .go     (go),
        .pause  (pause)
`ifdef TRIGGER_MANAGER_TIMEOUT_EN
        ,
        .timeout(timeout)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_reset();
        m_phase      = 0;
        m_pause_left = 0;
        m_prep_age   = 0;
        m_to         = 1'b0;
    endtask

    task automatic model_edge(input logic t, input logic r, input logic d);
        m_to = 1'b0;
        case (m_phase)
            0: if (t) begin m_phase = 1; m_prep_age = 0; end
            1: begin
                if (r) m_phase = 2;
                else begin
                    m_prep_age = m_prep_age + 1;
`ifdef TRIGGER_MANAGER_TIMEOUT_EN
                    if (m_prep_age == TIMEOUT_N) begin
                        m_phase = 3; m_pause_left = PAUSE_N; m_to = 1'b1;
                    end
`endif
                end
            end
            2: if (d) begin m_phase = 3; m_pause_left = PAUSE_N; end
            default: begin
                m_pause_left = m_pause_left - 1;
                if (m_pause_left == 0) m_phase = 0;
            end
        endcase
    endtask

    task automatic check_bit(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic check_outputs(input string tag);
        check_bit({tag, ".prepare"}, prepare, logic'(m_phase == 1));
        check_bit({tag, ".go"},      go,      logic'(m_phase == 2));
        check_bit({tag, ".pause"},   pause,   logic'(m_phase == 3));
`ifdef TRIGGER_MANAGER_TIMEOUT_EN
        check_bit({tag, ".timeout"}, timeout, logic'(m_to));
`endif
    endtask

    // Drive inputs mid-cycle, let one rising edge happen, then sample 1 ns later.
    task automatic step(input string tag, input logic t, input logic r, input logic d);
        @(negedge clk);
        trigger = t;
        ready   = r;
        done    = d;
        @(posedge clk);
        model_edge(t, r, d);
        #1;
        check_outputs(tag);
    endtask

    task automatic async_reset(input string tag);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_outputs(tag);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        rst_n   = 1'b0;
        trigger = 1'b0;
        ready   = 1'b0;
        done    = 1'b0;
        model_reset();

        // Reset state while rst_n held low across edges, even with trigger high
        trigger = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_outputs("reset_hold");
        @(negedge clk);
        trigger = 1'b0;
        rst_n   = 1'b1;

        // Basic sequence
        step("idle0",      1'b0, 1'b0, 1'b0);
        step("trig",       1'b1, 1'b0, 1'b0);
        step("prep_wait",  1'b0, 1'b0, 1'b0);
        step("ready",      1'b0, 1'b1, 1'b0);
        step("run_wait",   1'b0, 1'b0, 1'b0);
        step("done",       1'b0, 1'b0, 1'b1);
        step("pause1",     1'b0, 1'b0, 1'b0);
        step("pause_end",  1'b0, 1'b0, 1'b0);
        step("idle1",      1'b0, 1'b0, 1'b0);
        check_bit("basic_all_low", prepare | go | pause, 1'b0);

        // Ignored inputs: ready and done in IDLE, trigger and ready in RUN, done in PREPARE with ready
        step("ign_ready_idle", 1'b0, 1'b1, 1'b0);
        step("ign_done_idle",  1'b0, 1'b0, 1'b1);
        step("trig2",          1'b1, 1'b0, 1'b0);
        step("ign_done_prep",  1'b0, 1'b0, 1'b1);
        step("ready_and_done", 1'b0, 1'b1, 1'b1);
        check_bit("rd_both_go", go, 1'b1);
        step("ign_trig_run",   1'b1, 1'b0, 1'b0);
        step("ign_ready_run",  1'b0, 1'b1, 1'b0);

        // Asynchronous reset while go is high: no pause window follows
        async_reset("async_rst_run");
        check_bit("async_rst_go", go, 1'b0);
        step("post_rst0", 1'b0, 1'b0, 1'b0);
        check_bit("post_rst_no_pause", pause, 1'b0);

        // Retrigger: trigger held through PAUSE restarts one cycle after pause drops
        step("rt_trig",   1'b1, 1'b0, 1'b0);
        step("rt_ready",  1'b1, 1'b1, 1'b0);
        step("rt_done",   1'b1, 1'b0, 1'b1);
        step("rt_pause2", 1'b1, 1'b0, 1'b0);
        step("rt_idle",   1'b1, 1'b0, 1'b0);
        check_bit("rt_gap_low", prepare | pause, 1'b0);
        step("rt_prep",   1'b1, 1'b0, 1'b0);
        check_bit("rt_prep_high", prepare, 1'b1);
        step("rt_drop",   1'b0, 1'b0, 1'b0);

        // PREPARE held without ready
        for (int i = 0; i < TIMEOUT_N + PAUSE_N + 2; i++) step("prep_hold", 1'b0, 1'b0, 1'b0);
        async_reset("async_rst_prep");

`ifdef TRIGGER_MANAGER_TIMEOUT_EN
        // Timeout: prepare for TIMEOUT_N cycles, then one timeout pulse with pause
        step("to_trig", 1'b1, 1'b0, 1'b0);
        for (int i = 1; i < TIMEOUT_N; i++) step("to_wait", 1'b0, 1'b0, 1'b0);
        step("to_fire", 1'b0, 1'b0, 1'b0);
        check_bit("to_pulse", timeout, 1'b1);
        step("to_pause2", 1'b0, 1'b0, 1'b0);
        check_bit("to_one_cycle", timeout, 1'b0);
        step("to_idle", 1'b0, 1'b0, 1'b0);
        // ready on the expiring edge wins
        step("tr_trig", 1'b1, 1'b0, 1'b0);
        for (int i = 1; i < TIMEOUT_N; i++) step("tr_wait", 1'b0, 1'b0, 1'b0);
        step("tr_ready_wins", 1'b0, 1'b1, 1'b0);
        check_bit("tr_no_pulse", timeout, 1'b0);
        async_reset("async_rst_tr");
`endif

        // Randomized traffic with occasional asynchronous resets
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 99) == 0) begin
                async_reset("rnd_rst");
            end else begin
                step("rnd",
                     logic'($urandom_range(0, 99) < 35),
                     logic'($urandom_range(0, 99) < 20),
                     logic'($urandom_range(0, 99) < 25));
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
